// File: rtl/demux_drv_pkg.sv
// Shared constants and types for the demux driver.
// Ack return path is built only with DEMUX_DRV_ACK_EN.
package demux_drv_pkg;

    localparam int SEL_W_DEF = 10;
    localparam int DEPTH_DEF = 4;
    localparam int ACK_LAT   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/demux_drv_fifo.sv
// Request FIFO for the demux driver.
// Full/empty come from the registered level.
module demux_drv_fifo #(
    parameter  int W     = 11,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop)
                level <= level + 1'b1;
            else if (do_pop && !do_push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/demux_drv.sv
// Queues steering requests and drives a demux tree select/data.
// Define DEMUX_DRV_ACK_EN to build the ack return path.
module demux_drv
    import demux_drv_pkg::*;
#(
    parameter  int SEL_W = SEL_W_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_data,
    input  logic             hold,
    input  logic             flush,
    output logic [SEL_W-1:0] dmx_sel,
    output logic             dmx_in,
    output logic             ack_valid,
    output logic [SEL_W-1:0] ack_sel,
    output logic [LW-1:0]    level
);

    state_t         state_q;
    state_t         state_d;
    logic           rdy_en;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           bit_q;
    logic [SEL_W:0] head;

    assign req_ready = rdy_en && !full;
    assign push      = req_valid && req_ready;

    always_comb begin
        state_d = IDLE;
        if (!empty && !hold && !flush)
            state_d = ISSUE;
    end

    assign pop = (state_d == ISSUE);

    demux_drv_fifo #(
        .W     (SEL_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({req_sel, req_data}),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_en  <= 1'b0;
            dmx_sel <= '0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_en  <= 1'b1;
            if (pop) begin
                dmx_sel <= head[SEL_W:1];
                bit_q   <= head[0];
            end
        end
    end

    // Idle cycles present 0 so every leaf captures 0.
    assign dmx_in = (state_q == ISSUE) && bit_q;

`ifdef DEMUX_DRV_ACK_EN
    logic [ACK_LAT-1:0] av_q;
    logic [SEL_W-1:0]   as_q [ACK_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            av_q <= '0;
            for (int i = 0; i < ACK_LAT; i++)
                as_q[i] <= '0;
        end else begin
            av_q[0] <= (state_q == ISSUE);
            as_q[0] <= (state_q == ISSUE) ? dmx_sel : '0;
            for (int i = 1; i < ACK_LAT; i++) begin
                av_q[i] <= av_q[i-1];
                as_q[i] <= as_q[i-1];
            end
        end
    end

    assign ack_valid = av_q[ACK_LAT-1];
    assign ack_sel   = as_q[ACK_LAT-1];
`else
    assign ack_valid = 1'b0;
    assign ack_sel   = '0;
`endif

endmodule

// File: tb/tb_demux_drv.sv
// Randomized self-checking bench for demux_drv.
// Ack expectations follow DEMUX_DRV_ACK_EN.
module tb_demux_drv;

    localparam int SW = 10;
    localparam int DP = 4;
    localparam int LW = 3;
    localparam int VW = 1 + LW + SW + 1 + 1 + SW;
`ifdef DEMUX_DRV_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [SW-1:0] req_sel = '0;
    logic          req_data = 1'b0;
    logic          hold = 1'b0;
    logic          flush = 1'b0;
    logic [SW-1:0] dmx_sel;
    logic          dmx_in;
    logic          ack_valid;
    logic [SW-1:0] ack_sel;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    demux_drv dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_data  (req_data),
        .hold      (hold),
        .flush     (flush),
        .dmx_sel   (dmx_sel),
        .dmx_in    (dmx_in),
        .ack_valid (ack_valid),
        .ack_sel   (ack_sel),
        .level     (level)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int            t;
        logic [SW-1:0] sel;
    } pend_t;

    logic [SW:0]   q [$];
    pend_t         pend [$];
    logic          m_rdy = 1'b0;
    logic [SW-1:0] m_sel = '0;
    logic          m_in  = 1'b0;
    logic          m_av  = 1'b0;
    logic [SW-1:0] m_as  = '0;

    // Reference: queue of requests, issue list with issue-edge times.
    function automatic void model();
        logic        do_pop;
        logic        do_push;
        logic [SW:0] e;
        pend_t       p;
        cyc++;
        m_av = 1'b0;
        m_as = '0;
        if (rst) begin
            q.delete();
            pend.delete();
            m_rdy = 1'b0;
            m_sel = '0;
            m_in  = 1'b0;
            return;
        end
        do_pop  = (q.size() > 0) && !hold && !flush;
        do_push = req_valid && m_rdy && (q.size() < DP) && !flush;
        m_in = 1'b0;
        if (do_pop) begin
            e = q.pop_front();
            m_sel = e[SW:1];
            m_in  = e[0];
            pend.push_back(pend_t'{t: cyc, sel: e[SW:1]});
        end
        if (do_push) q.push_back({req_sel, req_data});
        if (flush) q.delete();
        if (pend.size() > 0 && pend[0].t + 2 == cyc) begin
            p = pend.pop_front();
            if (ACK_EN) begin
                m_av = 1'b1;
                m_as = p.sel;
            end
        end
        m_rdy = 1'b1;
    endfunction

    function automatic logic [VW-1:0] expv();
        logic r;
        r = m_rdy && (q.size() < DP);
        return {r, LW'(q.size()), m_sel, m_in, m_av, m_as};
    endfunction

    function automatic logic [VW-1:0] actv();
        logic [SW-1:0] s;
        s = ack_valid ? ack_sel : '0;
        return {req_ready, level, dmx_sel, dmx_in, ack_valid, s};
    endfunction

    function automatic logic can_acc();
        return m_rdy && (q.size() < DP);
    endfunction

    task automatic step(input logic r, input logic v,
                        input logic [SW-1:0] s, input logic d,
                        input logic h, input logic f);
        rst = r; req_valid = v; req_sel = s;
        req_data = d; hold = h; flush = f;
        @(posedge clk);
        model();
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 0, '0, 0, 0, 0);
            checks++;
            if (actv() !== '0) begin
                errors++;
                $display("FAIL reset_state got=%h want=0", actv());
            end
        end
        step(0, 0, '0, 0, 0, 0);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b want=1",
                     req_ready);
        end
    endtask

    task automatic test_single();
        for (int k = 0; k < 6; k++) begin
            step(0, k == 0, SW'('h2A5), 1, 0, 0);
            checks++;
            if (actv() !== expv()) begin
                errors++;
                $display("FAIL single cyc=%0d got=%h want=%h",
                         cyc, actv(), expv());
            end
            checks++;
            if (k == 1 && {dmx_sel, dmx_in} !== {10'h2A5, 1'b1}) begin
                errors++;
                $display("FAIL single_dmx got=%h/%b want=2a5/1",
                         dmx_sel, dmx_in);
            end else if (k != 1 && dmx_in !== 1'b0) begin
                errors++;
                $display("FAIL single_dmx_idle k=%0d got=%b want=0",
                         k, dmx_in);
            end
            checks++;
            if (k == 3 && {ack_valid, ack_sel} !==
                (ACK_EN ? {1'b1, 10'h2A5} : 11'h0)) begin
                errors++;
                $display("FAIL single_ack got=%b/%h want_en=%b",
                         ack_valid, ack_sel, ACK_EN);
            end else if (k != 3 && ack_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_ack_idle k=%0d got=%b want=0",
                         k, ack_valid);
            end
        end
    endtask

    task automatic test_fill_backpressure();
        logic [5*SW-1:0] got;
        logic            acc5;
        logic            v;
        int              n;
        got  = '0;
        acc5 = 1'b0;
        n    = 0;
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, SW'(i), 1, 1, 0);
            checks++;
            if (actv() !== expv()) begin
                errors++;
                $display("FAIL fill cyc=%0d got=%h want=%h",
                         cyc, actv(), expv());
            end
        end
        checks++;
        if (level !== 3'd4 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got=%0d/%b want=4/0",
                     level, req_ready);
        end
        for (int i = 0; i < 12; i++) begin
            v = !acc5;
            if (v && can_acc()) acc5 = 1'b1;
            step(0, v, SW'(5), 1, 0, 0);
            checks++;
            if (actv() !== expv()) begin
                errors++;
                $display("FAIL fill_drain cyc=%0d got=%h want=%h",
                         cyc, actv(), expv());
            end
            if (dmx_in === 1'b1) begin
                got = {got[4*SW-1:0], dmx_sel};
                n++;
            end
        end
        checks++;
        if (n != 5 || got !== {10'd1, 10'd2, 10'd3, 10'd4, 10'd5}) begin
            errors++;
            $display("FAIL fill_order n=%0d got=%h want=1..5", n, got);
        end
    endtask

    task automatic test_back_to_back();
        step(0, 1, SW'($urandom), 1, 1, 0);
        step(0, 1, SW'($urandom), 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, SW'($urandom), 1'($urandom), 0, 0);
            checks++;
            if (actv() !== expv() || level !== 3'd2) begin
                errors++;
                $display("FAIL stream cyc=%0d got=%h want=%h",
                         cyc, actv(), expv());
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 0, '0, 0, 0, 0);
            checks++;
            if (actv() !== expv()) begin
                errors++;
                $display("FAIL stream_drain cyc=%0d got=%h want=%h",
                         cyc, actv(), expv());
            end
        end
    endtask

    task automatic test_flush();
        int acks;
        int ones;
        acks = 0;
        ones = 0;
        for (int i = 0; i < 4; i++)
            step(0, 1, SW'(10'h100 + i), 1, 1, 0);
        step(0, 0, '0, 0, 0, 0);
        step(0, 1, SW'(10'h3FF), 1, 0, 1);
        checks++;
        if (level !== '0) begin
            errors++;
            $display("FAIL flush_level got=%0d want=0", level);
        end
        if (ack_valid === 1'b1) acks++;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, '0, 0, 0, 0);
            checks++;
            if (actv() !== expv()) begin
                errors++;
                $display("FAIL flush cyc=%0d got=%h want=%h",
                         cyc, actv(), expv());
            end
            if (ack_valid === 1'b1) acks++;
            if (dmx_in === 1'b1) ones++;
        end
        checks++;
        if (acks != int'(ACK_EN) || ones != 0) begin
            errors++;
            $display("FAIL flush_acks got=%0d/%0d want=%0d/0",
                     acks, ones, ACK_EN);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++)
            step(0, 1, SW'(10'h050 + i), 1, 1, 0);
        step(0, 0, '0, 0, 0, 0);
        step(1, 0, '0, 0, 0, 0);
        checks++;
        if (actv() !== '0) begin
            errors++;
            $display("FAIL rst_mid got=%h want=0", actv());
        end
        step(0, 0, '0, 0, 0, 0);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready got=%b want=1", req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, '0, 0, 0, 0);
            checks++;
            if (actv() !== expv() || ack_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_ack cyc=%0d got=%h want=%h",
                         cyc, actv(), expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 1'($urandom),
                 SW'($urandom),
                 1'($urandom),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0);
            checks++;
            if (actv() !== expv()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h",
                         cyc, actv(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
